// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mac_feeder
// Purpose  : Upstream sequencer for the 16-lane MAC/accumulate/sigmoid neuron
//            stage. Captures one 28x28 8-bit image from a byte stream into a
//            49 x 128-bit chunk buffer. For each neuron it clears the
//            accumulator, streams 49 pixel/weight chunk pairs (weights from a
//            synchronous ROM), waits for the pipeline to drain and then pulses
//            result_valid so the consumer can sample that neuron's sig_out.
// Ports    : clk, reset (async, active-high)
//            pix_in/pix_valid/pix_ready : image byte stream in
//            start                      : begin evaluation (READY only)
//            busy                       : CLR of neuron 0 .. EMIT of last neuron
//            wt_addr/wt_data            : weight ROM (1-cycle read latency)
//            pixels/weights             : chunk pair to the MAC lanes
//            acc_clr                    : accumulator clear
//            neuron_idx/result_valid    : result qualifier for sig_out
// Revision : 1.0 - initial release
// ============================================================================
module mac_feeder #(
    parameter int NPIX     = 784,
    parameter int LANES    = 16,
    parameter int NCHUNK   = 49,
    parameter int NNEURON  = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic         start,
    output logic         busy,
    output logic [8:0]   wt_addr,
    input  logic [127:0] wt_data,
    output logic [127:0] pixels,
    output logic [127:0] weights,
    output logic         acc_clr,
    output logic [3:0]   neuron_idx,
    output logic         result_valid
);

    localparam int WP_W = $clog2(NPIX + 1);
    localparam int C_W  = $clog2(NCHUNK);
    localparam int L_W  = $clog2(LANES);
    localparam int D_W  = $clog2(PIPE_LAT + 2);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_READY  = 3'd1,
        S_CLR    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_EMIT   = 3'd5
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WP_W-1:0]     wr_ptr;
    logic [C_W-1:0]      chunk_cnt;
    logic [D_W-1:0]      drain_cnt;
    logic                present;
    logic [127:0]        chunk_buf [NCHUNK];

    logic [C_W-1:0]      wr_chunk;
    logic [L_W-1:0]      wr_lane;
    logic                last_neuron;

    assign wr_chunk    = C_W'(wr_ptr / WP_W'(LANES));
    assign wr_lane     = L_W'(wr_ptr % WP_W'(LANES));
    assign last_neuron = (neuron_idx == 4'(NNEURON - 1));

    // pix_ready is the only non-registered output: a pure state decode
    assign pix_ready = (state == S_LOAD);

    // The ROM's own output register is the pipeline stage for weights; it
    // lines up with the registered buffer read, so only gating is needed here.
    assign weights = present ? wt_data : '0;

    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:   if (pix_valid && (wr_ptr == WP_W'(NPIX - 1))) next_state = S_READY;
            S_READY:  if (start) next_state = S_CLR;
            S_CLR:    next_state = S_STREAM;
            S_STREAM: if (chunk_cnt == C_W'(NCHUNK - 1)) next_state = S_DRAIN;
            S_DRAIN:  if (drain_cnt == D_W'(PIPE_LAT)) next_state = S_EMIT;
            S_EMIT:   next_state = last_neuron ? S_LOAD : S_CLR;
            default:  next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LOAD;
            wr_ptr       <= '0;
            chunk_cnt    <= '0;
            drain_cnt    <= '0;
            neuron_idx   <= '0;
            wt_addr      <= '0;
            busy         <= 1'b0;
            acc_clr      <= 1'b0;
            result_valid <= 1'b0;
            present      <= 1'b0;
            pixels       <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != S_LOAD) && (next_state != S_READY);
            acc_clr      <= (next_state == S_CLR);
            result_valid <= (next_state == S_EMIT);
            // chunk read in STREAM cycle c is presented in cycle c+1
            present      <= (state == S_STREAM);
            pixels       <= (state == S_STREAM) ? chunk_buf[chunk_cnt] : '0;

            case (state)
                S_LOAD: begin
                    if (pix_valid) wr_ptr <= wr_ptr + 1'b1;
                end
                S_READY: begin
                    if (start) begin
                        neuron_idx <= '0;
                        wt_addr    <= '0;
                    end
                end
                S_CLR: begin
                    chunk_cnt <= '0;
                end
                S_STREAM: begin
                    // wt_addr parks on the last chunk so +1 later is the next neuron's base
                    if (chunk_cnt != C_W'(NCHUNK - 1)) begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                        wt_addr   <= wt_addr + 1'b1;
                    end else begin
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                S_EMIT: begin
                    if (last_neuron) begin
                        neuron_idx <= '0;
                        wt_addr    <= '0;
                        wr_ptr     <= '0;
                    end else begin
                        neuron_idx <= neuron_idx + 1'b1;
                        wt_addr    <= wt_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Image buffer has no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if ((state == S_LOAD) && pix_valid) begin
            chunk_buf[wr_chunk][{wr_lane, 3'b000} +: 8] <= pix_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_feeder
// Purpose  : Directed self-checking bench for mac_feeder: image load with and
//            without stalls, per-cycle schedule of a full 10-neuron run with a
//            tagged ROM model, stray start pulses, and reset mid-run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_feeder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   pix_in = 8'h00;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic         start = 1'b0;
    logic         busy;
    logic [8:0]   wt_addr;
    logic [127:0] wt_data = '0;
    logic [127:0] pixels;
    logic [127:0] weights;
    logic         acc_clr;
    logic [3:0]   neuron_idx;
    logic         result_valid;

    int checks = 0;
    int fails  = 0;

    mac_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .start        (start),
        .busy         (busy),
        .wt_addr      (wt_addr),
        .wt_data      (wt_data),
        .pixels       (pixels),
        .weights      (weights),
        .acc_clr      (acc_clr),
        .neuron_idx   (neuron_idx),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Tagged weight word: every 16-bit slice is {7'h55, address}
    function automatic logic [127:0] rom_word(input logic [8:0] a);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = {7'h55, a};
        return r;
    endfunction

    // Synchronous ROM model: one cycle read latency
    always @(posedge clk) wt_data <= rom_word(wt_addr);

    // Expected chunk c when byte k of the image was loaded as (k + off) mod 256
    function automatic logic [127:0] exp_chunk(input int c, input int off);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'((16*c + i + off) % 256);
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (acc_clr !== 1'b0) begin fails++; $display("FAIL reset_acc_clr: got %b want 0", acc_clr); end
        checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        checks++; if (wt_addr !== 9'd0) begin fails++; $display("FAIL reset_wt_addr: got %0d want 0", wt_addr); end
        checks++; if (neuron_idx !== 4'd0) begin fails++; $display("FAIL reset_neuron_idx: got %0d want 0", neuron_idx); end
        checks++; if (pixels !== 128'd0) begin fails++; $display("FAIL reset_pixels: got %h want 0", pixels); end
        checks++; if (weights !== 128'd0) begin fails++; $display("FAIL reset_weights: got %h want 0", weights); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL post_reset_pix_ready: got %b want 1", pix_ready); end
    endtask

    // Streams 784 bytes (k + off) mod 256; checks pix_ready drops right after the last one
    task automatic load_image(input string name, input int off, input bit stall, input bit with_start);
        int k = 0;
        int cyc = 0;
        while (k < 784 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            pix_valid = stall ? ((cyc % 2) == 1) : 1'b1;
            pix_in    = 8'((k + off) % 256);
            start     = with_start;
            if (pix_valid && pix_ready) k++;
        end
        @(negedge clk);
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'hEE;
        checks++; if (k != 784) begin fails++; $display("FAIL %s_accepted: got %0d want 784", name, k); end
        checks++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_drop: got %b want 0", name, pix_ready); end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_held: got %b want 0", name, pix_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_in_ready: got %b want 0", name, busy); end
    endtask

    // Pulses start (cycle 0) and checks every output each cycle 1..stop_t
    task automatic run_schedule(input string name, input int off, input bit stray, input int stop_t);
        int n, p, c;
        logic e_busy, e_clr, e_rv;
        logic [3:0] e_idx;
        logic [8:0] e_addr;
        logic [127:0] e_pix, e_wt;
        @(negedge clk);
        start = 1'b1;
        pix_valid = 1'b0;
        for (int t = 1; t <= stop_t; t++) begin
            @(negedge clk);
            start     = stray && (t == 200 || t == 300);
            pix_valid = (t < 540);
            pix_in    = 8'h77;
            e_pix = '0; e_wt = '0; e_addr = '0;
            if (t <= 540) begin
                n = (t - 1) / 54;
                p = (t - 1) % 54;
                e_busy = 1'b1; e_clr = (p == 0); e_rv = (p == 53); e_idx = 4'(n);
                e_addr = 9'(n*49 + ((p == 0) ? 0 : p - 1));
                if (p >= 2 && p <= 50) begin
                    c = p - 2;
                    e_pix = exp_chunk(c, off);
                    e_wt  = rom_word(9'(n*49 + c));
                end
            end else begin
                p = -1;
                e_busy = 1'b0; e_clr = 1'b0; e_rv = 1'b0; e_idx = 4'd0;
                checks++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL %s_pix_ready t=%0d: got %b want 1", name, t, pix_ready); end
            end
            checks++; if (busy !== e_busy) begin fails++; $display("FAIL %s_busy t=%0d: got %b want %b", name, t, busy, e_busy); end
            checks++; if (acc_clr !== e_clr) begin fails++; $display("FAIL %s_acc_clr t=%0d: got %b want %b", name, t, acc_clr, e_clr); end
            checks++; if (result_valid !== e_rv) begin fails++; $display("FAIL %s_result_valid t=%0d: got %b want %b", name, t, result_valid, e_rv); end
            checks++; if (neuron_idx !== e_idx) begin fails++; $display("FAIL %s_neuron_idx t=%0d: got %0d want %0d", name, t, neuron_idx, e_idx); end
            checks++; if (pixels !== e_pix) begin fails++; $display("FAIL %s_pixels t=%0d: got %h want %h", name, t, pixels, e_pix); end
            checks++; if (weights !== e_wt) begin fails++; $display("FAIL %s_weights t=%0d: got %h want %h", name, t, weights, e_wt); end
            if (p >= 0 && p <= 49) begin
                checks++; if (wt_addr !== e_addr) begin fails++; $display("FAIL %s_wt_addr t=%0d: got %0d want %0d", name, t, wt_addr, e_addr); end
            end
        end
        start = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic test_load_no_stall();
        load_image("load_nostall", 0, 1'b0, 1'b1);
    endtask

    task automatic test_run_with_stray_start();
        run_schedule("run_stray", 0, 1'b1, 545);
    endtask

    task automatic test_load_stalled();
        load_image("load_stall", 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int rv_seen = 0;
        int busy_seen = 0;
        // ends at neuron 3, chunk 20 (cycle 183)
        run_schedule("run_pre_reset", 0, 1'b0, 183);
        reset = 1'b1;
        #1;
        checks++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL midrst_pix_ready: got %b want 1", pix_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (acc_clr !== 1'b0) begin fails++; $display("FAIL midrst_acc_clr: got %b want 0", acc_clr); end
        checks++; if (wt_addr !== 9'd0) begin fails++; $display("FAIL midrst_wt_addr: got %0d want 0", wt_addr); end
        checks++; if (neuron_idx !== 4'd0) begin fails++; $display("FAIL midrst_neuron_idx: got %0d want 0", neuron_idx); end
        checks++; if (pixels !== 128'd0) begin fails++; $display("FAIL midrst_pixels: got %h want 0", pixels); end
        checks++; if (weights !== 128'd0) begin fails++; $display("FAIL midrst_weights: got %h want 0", weights); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) rv_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        checks++; if (rv_seen != 0) begin fails++; $display("FAIL midrst_no_result: got %0d pulses want 0", rv_seen); end
        checks++; if (busy_seen != 0) begin fails++; $display("FAIL midrst_idle_busy: got %0d cycles want 0", busy_seen); end
        checks++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL midrst_idle_ready: got %b want 1", pix_ready); end
    endtask

    task automatic test_reload_and_run();
        load_image("reload", 100, 1'b0, 1'b0);
        run_schedule("rerun", 100, 1'b0, 545);
    endtask

    initial begin
        test_reset();
        test_load_no_stall();
        test_run_with_stray_start();
        test_load_stalled();
        test_reset_mid_run();
        test_reload_and_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Upstream sequencer for the 16-lane MAC/accumulate/sigmoid neuron stage.
- Captures one 28x28 8-bit image from a byte stream into a local 49 x 128-bit chunk buffer.
- For each of NNEURON neurons: clears the accumulator, then streams 49 packed pixel/weight chunk pairs, taking weights from a synchronous weight ROM.
- After pipeline drain, pulses result_valid so the consumer samples that neuron's sig_out.

Parameters:
- NPIX, 784, pixels per image.
- LANES, 16, bytes per 128-bit chunk.
- NCHUNK, 49, chunks per image (NPIX/LANES).
- NNEURON, 10, neurons evaluated per image.
- PIPE_LAT, 2, register stages from pixels/weights to the settled accumulator/sigmoid output.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_in  in  8  pixel byte.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  feeder accepts a byte this cycle.
- start  in  1  begin evaluation; honoured only in READY.
- busy  out  1  high from CLR of neuron 0 through EMIT of the last neuron.
- wt_addr  out  9  weight ROM address = neuron*NCHUNK + chunk; ROM data returns 1 cycle later.
- wt_data  in  128  ROM read data.
- pixels  out  128  chunk to MAC, lane k at bits [8k+7:8k].
- weights  out  128  weight chunk to MAC.
- acc_clr  out  1  accumulator clear, driven to the accumulator reset.
- neuron_idx  out  4  neuron currently being evaluated/emitted.
- result_valid  out  1  one-cycle pulse: sig_out for neuron_idx is valid.

Behaviour:
- Reset (async) values:
  - state=LOAD, write pointer=0.
  - pix_ready=1.
  - busy=0, acc_clr=0, result_valid=0.
  - pixels=0, weights=0, wt_addr=0, neuron_idx=0.
  - Buffer contents are don't-care.
- Registered outputs: all outputs are registered except pix_ready, which is a decode of state.
- States: LOAD, READY, CLR, STREAM, DRAIN, EMIT.
- LOAD:
  - pix_ready=1; a transfer occurs when pix_valid&pix_ready.
  - Byte k is written to chunk k/16, lane k%16.
  - On transfer 783 -> READY. pix_ready=0 from the next cycle.
  - start is ignored in LOAD.
- READY:
  - Waits for start; start=1 -> CLR with neuron_idx=0.
  - pix_valid is ignored.
- CLR:
  - One cycle, acc_clr=1, wt_addr=neuron_idx*49.
  - -> STREAM with chunk counter c=0.
- STREAM:
  - Exactly 49 cycles; at cycle c, wt_addr=neuron_idx*49+c.
  - Buffer read is registered, so chunk c is presented on pixels/weights (weights=wt_data) in cycle c+1.
  - After c=48 -> DRAIN.
- pixels/weights are forced to 0 in every cycle that does not present a valid chunk. The MAC therefore adds zero outside a stream.
- DRAIN: PIPE_LAT+1 cycles (covers the final presented chunk plus the pipeline), then -> EMIT.
- EMIT:
  - One cycle, result_valid=1 with neuron_idx held.
  - If neuron_idx<NNEURON-1: neuron_idx+1, -> CLR.
  - Else -> LOAD with write pointer=0, busy=0 next cycle, neuron_idx=0. The image is discarded.
- Timing:
  - Per neuron: 1+49+(PIPE_LAT+1)+1 = 54 cycles at default.
  - If start is sampled at cycle 0, result_valid pulses at cycles 54, 108, ..., 540.
- Arithmetic: wt_addr max 9*49+48=489, fits in 9 bits. Counters do not wrap within a run.
- Simultaneous events: start together with the final pixel byte is ignored, because start is checked only in READY. start while busy is ignored.
- Reset mid-operation: immediate return to the reset state. A partial image is lost and result_valid is not issued. The accumulator is not cleared until the next CLR.

Test Plan:
- Load bytes 0..783 as value (k mod 256), with no stalls -> pix_ready falls the cycle after byte 783 is accepted. The chunk 0 presented is 0x0F0E...0100 (lane0=0x00), and chunk 48 is lanes 768..783 mod 256, i.e. 0x0F0E...0100.
- Load with pix_valid toggling every other cycle -> exactly 784 bytes are accepted and the packing is identical to the no-stall case.
- Start with a ROM model returning 128'h{neuron,chunk}-tagged data -> acc_clr high 1 cycle at cycle 1, and wt_addr steps 0..48, 49..97, ..., 441..489. weights equals the tagged data, one cycle delayed. pixels/weights are 0 in CLR/DRAIN/EMIT.
- Full run from start at cycle 0 -> result_valid at cycles 54,108,...,540 with neuron_idx 0..9. busy=0 from cycle 541, state LOAD, pix_ready=1.
- start pulsed during LOAD and again mid-run -> no effect; the schedule is unchanged.
- Assert reset at neuron 3 chunk 20 -> all outputs return to reset values immediately, no further result_valid, pix_ready=1. A new 784-byte load plus start gives a correct full run.
